// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared CRC framer types and standard polynomials
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        CRC  = 2'd2
    } crc_state_t;

    // Generator polynomials, implicit top term omitted
    localparam logic [7:0]  CRC8_ATM    = 8'h07;
    localparam logic [15:0] CRC16_CCITT = 16'h1021;
    localparam logic [31:0] CRC32       = 32'h04C11DB7;

endpackage

// File: rtl/crc_stream_tx_if.sv
// rtl/crc_stream_tx_if.sv - payload input and framed output stream bundle
interface crc_stream_tx_if #(
    parameter int DW = 40
) ();
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready;

    // Framer side
    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last
    );

    // Source/sink side
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/crc_word_step.sv
// rtl/crc_word_step.sv - combinational MSB-first CRC advance over one data word
module crc_word_step #(
    parameter int                DW     = 40,
    parameter int                CRC_BW = 8,
    parameter logic [CRC_BW-1:0] POLY   = 8'h07
) (
    input  logic [CRC_BW-1:0] crc_in,
    input  logic [DW-1:0]     data,
    output logic [CRC_BW-1:0] crc_out
);

    logic [CRC_BW-1:0] acc;

    // Unrolled bit-serial LFSR: word MSB is shifted in first
    always_comb begin
        acc = crc_in;
        for (int i = DW - 1; i >= 0; i--) begin
            if (acc[CRC_BW-1] ^ data[i]) begin
                acc = (acc << 1) ^ POLY;
            end else begin
                acc = acc << 1;
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/crc_stream_tx.sv
// rtl/crc_stream_tx.sv - streaming framer appending a CRC beat after each frame
module crc_stream_tx
    import crc_pkg::*;
#(
    parameter int                DW     = 40,
    parameter int                CRC_BW = 8,
    parameter logic [CRC_BW-1:0] POLY   = CRC8_ATM,
    parameter logic [CRC_BW-1:0] INIT   = '0,
    parameter logic [CRC_BW-1:0] XOROUT = '0,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    crc_stream_tx_if.slave    bus,
    output logic [CNT_W-1:0]  frame_cnt
);

    generate
        if (DW < CRC_BW) begin : g_bad_width
            $error("crc_stream_tx: DW must be >= CRC_BW");
        end
    endgenerate

    crc_state_t        state;
    crc_state_t        state_nxt;
    logic [CRC_BW-1:0] crc;
    logic [CRC_BW-1:0] crc_acc;
    logic [CRC_BW-1:0] crc_step;
    logic [DW-1:0]     out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic              load;
    logic              accept;

    // Output register is free when empty or being drained this cycle
    assign load     = !out_valid_q || bus.out_ready;
    // No new payload while the CRC beat is waiting for its slot
    assign bus.in_ready = load && (state != CRC);
    assign accept   = bus.in_valid && bus.in_ready;
    // First word of a frame always starts from INIT
    assign crc_acc  = (state == IDLE) ? INIT : crc;

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;

    crc_word_step #(
        .DW     (DW),
        .CRC_BW (CRC_BW),
        .POLY   (POLY)
    ) u_step (
        .crc_in  (crc_acc),
        .data    (bus.in_data),
        .crc_out (crc_step)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: last word moves to CRC slot, CRC beat returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DATA: begin
                if (accept) begin
                    state_nxt = bus.in_last ? CRC : DATA;
                end
            end
            CRC: begin
                if (load) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output register and running CRC; everything holds while the sink stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            crc         <= INIT;
        end else if (load) begin
            if (accept) begin
                out_data_q  <= bus.in_data;
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
                crc         <= crc_step;
            end else if (state == CRC) begin
                out_data_q  <= DW'(crc ^ XOROUT);
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b1;
                crc         <= INIT;
            end else begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    // Count completed frames as their CRC beat leaves
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (out_valid_q && bus.out_ready && out_last_q) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_crc_stream_tx.sv
// tb/tb_crc_stream_tx.sv - directed self-checking bench for crc_stream_tx
module tb_crc_stream_tx;
    import crc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    crc_stream_tx_if #(.DW(40)) a_if ();
    crc_stream_tx_if #(.DW(8))  b_if ();
    crc_stream_tx_if #(.DW(16)) c_if ();
    crc_stream_tx_if #(.DW(8))  d_if ();

    logic [15:0] a_cnt;
    logic [15:0] b_cnt;
    logic [15:0] c_cnt;
    logic [1:0]  d_cnt;

    crc_stream_tx #(.DW(40), .CRC_BW(8), .POLY(CRC8_ATM), .INIT(8'h00), .XOROUT(8'h00), .CNT_W(16))
        u_a (.clk(clk), .rst(rst), .bus(a_if.slave), .frame_cnt(a_cnt));
    crc_stream_tx #(.DW(8), .CRC_BW(8), .POLY(CRC8_ATM), .INIT(8'h00), .XOROUT(8'h00), .CNT_W(16))
        u_b (.clk(clk), .rst(rst), .bus(b_if.slave), .frame_cnt(b_cnt));
    crc_stream_tx #(.DW(16), .CRC_BW(16), .POLY(CRC16_CCITT), .INIT(16'hFFFF), .XOROUT(16'h0000), .CNT_W(16))
        u_c (.clk(clk), .rst(rst), .bus(c_if.slave), .frame_cnt(c_cnt));
    crc_stream_tx #(.DW(8), .CRC_BW(8), .POLY(CRC8_ATM), .INIT(8'h00), .XOROUT(8'h00), .CNT_W(2))
        u_d (.clk(clk), .rst(rst), .bus(d_if.slave), .frame_cnt(d_cnt));

    // Polynomial long division of the init-masked message, independent of the LFSR form
    function automatic logic [15:0] crc16_ref(input logic [15:0] d);
        logic [31:0] r;
        r = {d ^ 16'hFFFF, 16'h0000};
        for (int i = 31; i >= 16; i--) begin
            if (r[i]) r = r ^ (32'h00011021 << (i - 16));
        end
        return r[15:0];
    endfunction

    // b sink: ready mode 0 = always ready, 1 = toggling with a 3-cycle stall on the CRC beat
    int   b_mode = 0;
    logic b_tog  = 1'b0;
    int   b_stall = 0;
    initial begin
        b_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (b_mode == 0) begin
                b_if.out_ready = 1'b1;
            end else if (b_if.out_valid && b_if.out_last) begin
                if (b_stall < 3) begin
                    b_if.out_ready = 1'b0;
                    b_stall++;
                end else begin
                    b_if.out_ready = 1'b1;
                end
            end else begin
                b_stall = 0;
                b_tog = !b_tog;
                b_if.out_ready = b_tog;
            end
        end
    end

    // b monitor: beat log, stall stability, run length, CRC-slot in_ready
    logic [64:0] b_log[$];
    logic        b_prev_stall = 1'b0;
    logic [8:0]  b_prev_beat  = '0;
    int          b_run = 0, b_last_run = 0;
    logic        b_slot = 1'b0;
    int          b_slot_cyc = 0, b_slot_viol = 0;
    always @(negedge clk) begin
        if (rst) begin
            b_prev_stall = 1'b0;
            b_run = 0;
            b_slot = 1'b0;
        end else begin
            if (b_prev_stall) begin
                check("b_hold_valid", 65'(b_if.out_valid), 65'd1);
                check("b_hold_beat", 65'({b_if.out_last, b_if.out_data}), 65'(b_prev_beat));
            end
            if (b_if.out_valid && b_if.out_ready) b_log.push_back(65'({b_if.out_last, b_if.out_data}));
            if (b_if.out_valid) b_run++;
            else begin
                if (b_run > 0) b_last_run = b_run;
                b_run = 0;
            end
            if (b_slot) begin
                if (b_if.out_valid && b_if.out_last) b_slot = 1'b0;
                else begin
                    b_slot_cyc++;
                    if (b_if.in_ready) b_slot_viol++;
                end
            end
            if (b_if.in_valid && b_if.in_ready && b_if.in_last) b_slot = 1'b1;
            b_prev_stall = b_if.out_valid && !b_if.out_ready;
            b_prev_beat  = {b_if.out_last, b_if.out_data};
        end
    end

    // Sends words 0x31.. of a frame of n_total words, stopping after n_send
    task automatic b_send_frame(input int n_send, input int n_total);
        int cyc;
        for (int i = 0; i < n_send; i++) begin
            @(posedge clk);
            #1;
            b_if.in_data  = 8'(8'h31 + i);
            b_if.in_valid = 1'b1;
            b_if.in_last  = (i == n_total - 1);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!b_if.in_ready && cyc < 50);
            if (cyc >= 50) check("b_send_timeout", 65'(cyc), 65'd0);
        end
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b0;
        b_if.in_last  = 1'b0;
    endtask

    task automatic b_wait_beats(input int base, input int n);
        int cyc = 0;
        while (b_log.size() < base + n && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("b_beat_count", 65'(b_log.size() - base), 65'(n));
    endtask

    task automatic b_check_frame(input int base);
        for (int i = 0; i < 9; i++) check("b_data_beat", b_log[base + i], 65'(32'h31 + i));
        check("b_crc_beat", b_log[base + 9], 65'h1F4);
    endtask

    logic [15:0] c_words[3] = '{16'h3132, 16'h3132, 16'h0000};
    logic [1:0]  d_exp[5]   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        rst = 1'b1;
        a_if.in_valid = 1'b0; a_if.in_last = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in_last = 1'b0; b_if.in_data = '0;
        c_if.in_valid = 1'b0; c_if.in_last = 1'b0; c_if.in_data = '0; c_if.out_ready = 1'b1;
        d_if.in_valid = 1'b0; d_if.in_last = 1'b0; d_if.in_data = '0; d_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 65'(a_if.out_valid), 65'd0);
        check("rst_last", 65'(a_if.out_last), 65'd0);
        check("rst_data", 65'(a_if.out_data), 65'd0);
        check("rst_cnt", 65'(a_cnt), 65'd0);

        // Case 1: single word 40'h1 on DW=40 CRC-8
        @(posedge clk);
        #1;
        a_if.in_data = 40'h1; a_if.in_valid = 1'b1; a_if.in_last = 1'b1;
        @(negedge clk);
        check("a_in_ready_idle", 65'(a_if.in_ready), 65'd1);
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
        @(negedge clk);
        check("a_data_beat", 65'({a_if.out_valid, a_if.out_last, a_if.out_data}), 65'({2'b10, 40'h1}));
        check("a_in_ready_slot", 65'(a_if.in_ready), 65'd0);
        @(negedge clk);
        check("a_crc_beat", 65'({a_if.out_valid, a_if.out_last, a_if.out_data}), 65'({2'b11, 40'h07}));
        @(negedge clk);
        check("a_idle_valid", 65'(a_if.out_valid), 65'd0);
        check("a_frame_cnt", 65'(a_cnt), 65'd1);

        // Case 2: "123456789" with continuous ready
        b_mode = 0;
        base = b_log.size();
        b_send_frame(9, 9);
        b_wait_beats(base, 10);
        b_check_frame(base);
        repeat (2) @(negedge clk);
        check("b_valid_run", 65'(b_last_run), 65'd10);
        check("b_cnt_case2", 65'(b_cnt), 65'd1);

        // Case 3: toggling ready, stalled CRC beat
        b_mode = 1;
        base = b_log.size();
        b_send_frame(9, 9);
        b_wait_beats(base, 10);
        b_check_frame(base);
        b_mode = 0;
        repeat (3) @(negedge clk);
        check("b_cnt_case3", 65'(b_cnt), 65'd2);
        check("b_slot_seen", 65'(b_slot_cyc > 0), 65'd1);
        check("b_slot_in_ready", 65'(b_slot_viol), 65'd0);

        // Case 4: abort after 4 words, then replay
        b_send_frame(4, 9);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("b_abort_valid", 65'(b_if.out_valid), 65'd0);
        check("b_abort_cnt", 65'(b_cnt), 65'd0);
        base = b_log.size();
        b_send_frame(9, 9);
        b_wait_beats(base, 10);
        b_check_frame(base);
        repeat (4) @(negedge clk);
        check("b_replay_beats", 65'(b_log.size() - base), 65'd10);
        check("b_cnt_replay", 65'(b_cnt), 65'd1);

        // Case 5: CRC-16 single-word frames back to back
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            c_if.in_data = c_words[i]; c_if.in_valid = 1'b1; c_if.in_last = 1'b1;
            @(negedge clk);
            check("c_in_ready", 65'(c_if.in_ready), 65'd1);
            @(posedge clk);
            #1;
            c_if.in_valid = 1'b0; c_if.in_last = 1'b0;
            @(negedge clk);
            check("c_data_beat", 65'({c_if.out_valid, c_if.out_last, c_if.out_data}), 65'({2'b10, c_words[i]}));
            @(negedge clk);
            check("c_crc_beat", 65'({c_if.out_valid, c_if.out_last, c_if.out_data}),
                  65'({2'b11, crc16_ref(c_words[i])}));
            @(negedge clk);
            check("c_frame_cnt", 65'(c_cnt), 65'(i + 1));
        end

        // Case 6: 2-bit frame counter wrap
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            d_if.in_data = 8'(8'hA0 + i); d_if.in_valid = 1'b1; d_if.in_last = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            d_if.in_valid = 1'b0; d_if.in_last = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("d_crc_last", 65'({d_if.out_valid, d_if.out_last}), 65'd3);
            @(negedge clk);
            check("d_frame_cnt", 65'(d_cnt), 65'(d_exp[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
